// File: rtl/sum_loop_engine.sv
// Self-sequenced accumulator: sums i = 1, 1+step, 1+2*step, ... while i <= limit,
// using a small register file, one adder, one comparator and a start/done handshake.
module sum_loop_engine #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 4,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] limit,
  input  logic [DATA_W-1:0] step,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] outport,
  output logic              ovf
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT_I = 3'd1;
  localparam logic [2:0] S_INIT_S = 3'd2;
  localparam logic [2:0] S_INIT_T = 3'd3;
  localparam logic [2:0] S_CMP    = 3'd4;
  localparam logic [2:0] S_ADD    = 3'd5;
  localparam logic [2:0] S_INC    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [AW-1:0] A_ZERO = AW'(0);
  localparam logic [AW-1:0] A_I    = AW'(1);
  localparam logic [AW-1:0] A_SUM  = AW'(2);
  localparam logic [AW-1:0] A_STEP = AW'(3);

  localparam logic [1:0] WSEL_ADD  = 2'd0;
  localparam logic [1:0] WSEL_ONE  = 2'd1;
  localparam logic [1:0] WSEL_STEP = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] lim_q;
  logic [DATA_W-1:0] stepp_q;
  logic              ovf_s_q;
  logic              iwrap_q;
  logic              done_q;
  logic [DATA_W-1:0] out_q;
  logic              ovf_q;

  logic [DATA_W-1:0] rf_q [REG_N];
  logic [REG_N-1:0]  we;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_a, rd_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   add_full;
  logic              carry;
  logic              in_range;

  assign op_a     = rf_q[rd_a];
  assign op_b     = rf_q[rd_b];
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign carry    = add_full[DATA_W];
  assign in_range = (rf_q[A_I] <= lim_q) && !iwrap_q;

  // Sequencer: one register-file write per state, operands picked by address.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = A_ZERO;
    wr_sel  = WSEL_ADD;
    rd_a    = A_ZERO;
    rd_b    = A_ZERO;
    case (state_q)
      S_IDLE:   if (start) state_d = S_INIT_I;
      S_INIT_I: begin
        wr_en = 1'b1; wr_addr = A_I; wr_sel = WSEL_ONE;
        state_d = S_INIT_S;
      end
      S_INIT_S: begin
        wr_en = 1'b1; wr_addr = A_SUM; wr_sel = WSEL_ADD;
        state_d = S_INIT_T;
      end
      S_INIT_T: begin
        wr_en = 1'b1; wr_addr = A_STEP; wr_sel = WSEL_STEP;
        state_d = S_CMP;
      end
      S_CMP:    state_d = in_range ? S_ADD : S_DONE;
      S_ADD: begin
        rd_a = A_SUM; rd_b = A_I;
        wr_en = 1'b1; wr_addr = A_SUM; wr_sel = WSEL_ADD;
        state_d = S_INC;
      end
      S_INC: begin
        rd_a = A_I; rd_b = A_STEP;
        wr_en = 1'b1; wr_addr = A_I; wr_sel = WSEL_ADD;
        state_d = S_CMP;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (wr_sel)
      WSEL_ONE:  wr_data = DATA_W'(1);
      WSEL_STEP: wr_data = stepp_q;
      default:   wr_data = add_full[DATA_W-1:0];
    endcase
  end

  // Entry 0 never gets a write enable, so it stays at its reset value of zero.
  generate
    for (genvar gi = 0; gi < REG_N; gi++) begin : g_we
      if (gi == 0) begin : g_zero
        assign we[gi] = 1'b0;
      end else begin : g_wr
        assign we[gi] = wr_en && (wr_addr == AW'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < REG_N; k++) begin
      if (reset) begin
        rf_q[k] <= '0;
      end else if (we[k]) begin
        rf_q[k] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      stepp_q <= '0;
      ovf_s_q <= 1'b0;
      iwrap_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      if (state_q == S_IDLE && start) begin
        lim_q   <= limit;
        stepp_q <= (step == '0) ? DATA_W'(1) : step;
        ovf_s_q <= 1'b0;
        iwrap_q <= 1'b0;
      end
      if (state_q == S_ADD) ovf_s_q <= ovf_s_q | carry;
      // A carry out of i means it wrapped past zero; stop rather than loop forever.
      if (state_q == S_INC) iwrap_q <= carry;
      if (state_q == S_DONE) begin
        out_q <= rf_q[A_SUM];
        ovf_q <= ovf_s_q;
      end
    end
  end

  always_comb begin
    dbg_rdata = '0;
    if (dbg_raddr != A_ZERO && int'(dbg_raddr) < REG_N) dbg_rdata = rf_q[dbg_raddr];
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign outport = out_q;
  assign ovf     = ovf_q;

endmodule
